registered_alu_pipe: RTL and testbench
======================================

REGISTERED_ALU_PIPE -- requirements
Module: registered_alu_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width (legal 4..64).
REQ-002 SHALL have parameter STAGES, default 1, input-to-output latency in cycles (legal 1..4).
REQ-003 SHALL have port clk_i  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port en_i  input  1  global enable; low freezes all pipeline state.
REQ-006 SHALL have port valid_i  input  1  operand beat offered.
REQ-007 SHALL have port ready_o  output  1  block accepts a beat this cycle.
REQ-008 SHALL have port a_i, b_i  input  WIDTH each  operands.
REQ-009 SHALL have port operation_i  input  3  opcode.
REQ-010 SHALL have port valid_o  output  1  result beat presented.
REQ-011 SHALL have port ready_i  input  1  downstream accepts the result beat.
REQ-012 SHALL have port result_o  output  WIDTH  registered result.
REQ-013 SHALL have ports zero_o, carry_o, overflow_o, negative_o  output  1 each  registered flags of result_o.

Function
REQ-014 SHALL decode operation_i: 000 AND, 001 OR, 010 ADD, 011 XOR, 100 NOR, 101 pass b_i, 110 SUB (a-b), 111 SLT (signed a<b gives 1, else 0).
REQ-015 SHALL wrap ADD/SUB modulo 2^WIDTH; carry_o = carry-out for ADD, borrow (unsigned a<b) for SUB, 0 otherwise.
REQ-016 SHALL set overflow_o on signed two's-complement overflow for ADD/SUB only, 0 otherwise.
REQ-017 SHALL set zero_o = (result_o == 0) and negative_o = result_o[WIDTH-1] for every opcode.
REQ-018 SHALL transfer an input beat only when valid_i & ready_o, and an output beat only when valid_o & ready_i.
REQ-019 SHALL compute in stage 1 and delay through STAGES-1 further register stages, each carrying a valid bit; with no back-pressure the result appears exactly STAGES cycles after acceptance.
REQ-020 SHALL advance a stage when it is empty or the next stage advances; ready_o = en_i & (stage 1 empty or stage 1 advancing), giving full throughput (one beat/cycle) when ready_i held high.
REQ-021 SHALL hold result_o, flags and valid_o stable while valid_o & !ready_i.
REQ-022 SHALL, when en_i low, hold every register, drive ready_o low and keep valid_o/result_o unchanged; handshakes on valid_o during en_i low SHALL not retire the beat.
REQ-023 SHALL preserve beat order; no beat dropped or duplicated, including simultaneous accept and retire when full.
REQ-024 SHALL ignore a_i, b_i, operation_i when no input transfer occurs.

Reset
REQ-025 SHALL, on rst_i high at a rising edge, clear all stage valid bits, set result_o to 0, zero_o to 1, carry_o/overflow_o/negative_o to 0, valid_o to 0.
REQ-026 SHALL discard in-flight beats on reset mid-operation; rst_i overrides en_i; ready_o SHALL be 0 while rst_i is high.

Structure
REQ-027 SHALL place opcode constants (OP_AND..OP_SLT) and a flags record type in shared package alu_pkg.
REQ-028 SHALL isolate the combinational datapath in sub-module alu_core (WIDTH-parameterised, result plus four flags); registered_alu_pipe owns only pipeline/handshake registers.
REQ-029 SHALL implement stages via a generate loop over STAGES; no latches, no multi-clock logic.

Verification
REQ-030 Reset, WIDTH=8: rst_i high two cycles -> valid_o=0, result_o=0x00, zero_o=1, ready_o=0 during reset.
REQ-031 STAGES=1, ready_i=1: ADD 0x3A,0x19 then SUB 0x3A,0x19 -> 0x53 then 0x21 on consecutive cycles, one cycle after each accept, zero_o=0.
REQ-032 SUB 0x0E,0x19 -> 0xF5, carry_o=1, negative_o=1; ADD 0x7F,0x01 -> 0x80, overflow_o=1; SUB 0x00,0x00 -> 0x00, zero_o=1.
REQ-033 STAGES=3: stream 8 back-to-back beats, ready_i low cycles 4-6 -> outputs held stable, ready_o drops once full, all 8 results in order, none lost.
REQ-034 en_i low two cycles mid-stream -> all outputs frozen, ready_o=0, stream resumes with correct order and latency.
REQ-035 rst_i asserted with 3 beats in flight -> valid_o=0 next cycle, earlier beats never appear; SLT 0xFE,0x01 after reset -> 0x01.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode and flag definitions for the registered ALU pipeline.
// Imported by alu_core and registered_alu_pipe.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_ADD  = 3'b010,
    OP_XOR  = 3'b011,
    OP_NOR  = 3'b100,
    OP_PASS = 3'b101,
    OP_SUB  = 3'b110,
    OP_SLT  = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic zero;
    logic carry;
    logic overflow;
    logic negative;
  } alu_flags_t;

  // Flags describing an all-zero result.
  localparam alu_flags_t FLAGS_RST = '{
    zero:     1'b1,
    carry:    1'b0,
    overflow: 1'b0,
    negative: 1'b0
  };

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: result plus zero/carry/overflow/negative.
// Ports: a_i, b_i operands; op_i opcode; result_o; flags_o.
import alu_pkg::*;

module alu_core #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  alu_op_e          op_i,
  output logic [WIDTH-1:0] result_o,
  output alu_flags_t       flags_o
);

  localparam int M = WIDTH - 1;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic             slt;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic             ovf;

  // Extra top bit holds carry-out (add) or borrow (sub).
  assign sum  = {1'b0, a_i} + {1'b0, b_i};
  assign diff = {1'b0, a_i} - {1'b0, b_i};
  assign slt  = $signed(a_i) < $signed(b_i);

  always_comb begin
    res   = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    unique case (op_i)
      OP_AND:  res = a_i & b_i;
      OP_OR:   res = a_i | b_i;
      OP_XOR:  res = a_i ^ b_i;
      OP_NOR:  res = ~(a_i | b_i);
      OP_PASS: res = b_i;
      OP_ADD: begin
        res   = sum[M:0];
        carry = sum[WIDTH];
        ovf   = (a_i[M] == b_i[M]) &
                (sum[M] != a_i[M]);
      end
      OP_SUB: begin
        res   = diff[M:0];
        carry = diff[WIDTH];
        ovf   = (a_i[M] != b_i[M]) &
                (diff[M] != a_i[M]);
      end
      OP_SLT:  res = {{M{1'b0}}, slt};
      default: res = '0;
    endcase
  end

  assign result_o         = res;
  assign flags_o.zero     = (res == '0);
  assign flags_o.carry    = carry;
  assign flags_o.overflow = ovf;
  assign flags_o.negative = res[M];

endmodule

// File: rtl/registered_alu_pipe.sv
// Valid/ready ALU pipeline: compute in stage 1, STAGES deep total.
// Ports: clk_i, rst_i (sync, high), en_i, valid_i/ready_o, a_i, b_i,
// operation_i in; valid_o/ready_i, result_o and four flags out.
import alu_pkg::*;

module registered_alu_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       operation_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             carry_o,
  output logic             overflow_o,
  output logic             negative_o
);

  localparam int L = STAGES - 1;

  logic [WIDTH-1:0] core_res;
  alu_flags_t       core_flg;

  alu_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .a_i      (a_i),
    .b_i      (b_i),
    .op_i     (alu_op_e'(operation_i)),
    .result_o (core_res),
    .flags_o  (core_flg)
  );

  logic             vld_s [STAGES];
  logic [WIDTH-1:0] res_s [STAGES];
  alu_flags_t       flg_s [STAGES];
  logic [STAGES:0]  adv;

  // A stage moves when empty or when its successor moves;
  // the virtual stage past the end moves when downstream is ready.
  always_comb begin
    adv         = '0;
    adv[STAGES] = ready_i;
    for (int i = L; i >= 0; i--) begin
      adv[i] = en_i & ~rst_i &
               (~vld_s[i] | adv[i+1]);
    end
  end

  assign ready_o = adv[0];

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic             vld_in;
    logic [WIDTH-1:0] res_in;
    alu_flags_t       flg_in;
    logic             vld_q;
    logic [WIDTH-1:0] res_q;
    alu_flags_t       flg_q;

    if (s == 0) begin : g_head
      assign vld_in = valid_i;
      assign res_in = core_res;
      assign flg_in = core_flg;
    end else begin : g_body
      assign vld_in = vld_s[s-1];
      assign res_in = res_s[s-1];
      assign flg_in = flg_s[s-1];
    end

    // Payload only loads with a real beat so an emptied
    // output keeps its last value instead of garbage.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        vld_q <= 1'b0;
        res_q <= '0;
        flg_q <= FLAGS_RST;
      end else if (adv[s]) begin
        vld_q <= vld_in;
        if (vld_in) begin
          res_q <= res_in;
          flg_q <= flg_in;
        end
      end
    end

    assign vld_s[s] = vld_q;
    assign res_s[s] = res_q;
    assign flg_s[s] = flg_q;
  end

  assign valid_o    = vld_s[L];
  assign result_o   = res_s[L];
  assign zero_o     = flg_s[L].zero;
  assign carry_o    = flg_s[L].carry;
  assign overflow_o = flg_s[L].overflow;
  assign negative_o = flg_s[L].negative;

endmodule

// File: tb/tb_registered_alu_pipe.sv
// Directed bench for registered_alu_pipe with STAGES=1 and STAGES=3
// instances sharing one stimulus bus.
module tb_registered_alu_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       vin;
  logic       rdy_in;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] op;

  logic       rdy1, vo1, z1, c1, o1, n1;
  logic [7:0] res1;
  logic       rdy3, vo3, z3, c3, o3, n3;
  logic [7:0] res3;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  registered_alu_pipe #(.WIDTH(8), .STAGES(1)) u1 (
    .clk_i(clk), .rst_i(rst), .en_i(en),
    .valid_i(vin), .ready_o(rdy1),
    .a_i(a), .b_i(b), .operation_i(op),
    .valid_o(vo1), .ready_i(rdy_in), .result_o(res1),
    .zero_o(z1), .carry_o(c1),
    .overflow_o(o1), .negative_o(n1)
  );

  registered_alu_pipe #(.WIDTH(8), .STAGES(3)) u3 (
    .clk_i(clk), .rst_i(rst), .en_i(en),
    .valid_i(vin), .ready_o(rdy3),
    .a_i(a), .b_i(b), .operation_i(op),
    .valid_o(vo3), .ready_i(rdy_in), .result_o(res3),
    .zero_o(z3), .carry_o(c3),
    .overflow_o(o3), .negative_o(n3)
  );

  task automatic do_reset();
    rst = 1'b1;
    vin = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; vin = 1'b0;
    rdy_in = 1'b1; a = '0; b = '0; op = '0;
    @(negedge clk);
    total++;
    if ({rdy1, rdy3} !== 2'b00)
      $display("FAIL rst_ready got %b want 00", {rdy1, rdy3});
    else pass_cnt++;
    @(negedge clk);
    total++;
    if ({rdy1, rdy3} !== 2'b00)
      $display("FAIL rst_ready2 got %b want 00", {rdy1, rdy3});
    else pass_cnt++;
    total++;
    if ({vo1, res1, z1, c1, o1, n1} !== {1'b0, 8'h00, 4'b1000})
      $display("FAIL rst_out1 got %b_%h_%b%b%b%b want 0_00_1000",
               vo1, res1, z1, c1, o1, n1);
    else pass_cnt++;
    total++;
    if ({vo3, res3, z3, c3, o3, n3} !== {1'b0, 8'h00, 4'b1000})
      $display("FAIL rst_out3 got %b_%h_%b%b%b%b want 0_00_1000",
               vo3, res3, z3, c3, o3, n3);
    else pass_cnt++;
    rst = 1'b0;
    #1;
    total++;
    if (rdy1 !== 1'b1)
      $display("FAIL post_rst_ready got %b want 1", rdy1);
    else pass_cnt++;
  endtask

  task automatic test_add_sub();
    vin = 1'b1; op = 3'b010; a = 8'h3A; b = 8'h19;
    @(negedge clk);
    total++;
    if ({vo1, res1, z1} !== {1'b1, 8'h53, 1'b0})
      $display("FAIL add got %b_%h_%b want 1_53_0", vo1, res1, z1);
    else pass_cnt++;
    op = 3'b110;
    @(negedge clk);
    total++;
    if ({vo1, res1, z1} !== {1'b1, 8'h21, 1'b0})
      $display("FAIL sub got %b_%h_%b want 1_21_0", vo1, res1, z1);
    else pass_cnt++;
    vin = 1'b0;
    @(negedge clk);
    total++;
    if (vo1 !== 1'b0)
      $display("FAIL drain_valid got %b want 0", vo1);
    else pass_cnt++;
  endtask

  task automatic test_flags();
    logic [2:0] t_op  [12] = '{3'd6, 3'd2, 3'd6, 3'd0, 3'd1, 3'd3,
                               3'd4, 3'd5, 3'd2, 3'd6, 3'd7, 3'd7};
    logic [7:0] t_a   [12] = '{8'h0E, 8'h7F, 8'h00, 8'hF0, 8'hF0, 8'hAA,
                               8'h0F, 8'h12, 8'hFF, 8'h80, 8'h01, 8'hFE};
    logic [7:0] t_b   [12] = '{8'h19, 8'h01, 8'h00, 8'h3C, 8'h0F, 8'hFF,
                               8'hF0, 8'h80, 8'h01, 8'h01, 8'hFE, 8'h01};
    logic [7:0] t_r   [12] = '{8'hF5, 8'h80, 8'h00, 8'h30, 8'hFF, 8'h55,
                               8'h00, 8'h80, 8'h00, 8'h7F, 8'h00, 8'h01};
    logic [3:0] t_f   [12] = '{4'b0101, 4'b0011, 4'b1000, 4'b0000,
                               4'b0001, 4'b0000, 4'b1000, 4'b0001,
                               4'b1100, 4'b0010, 4'b1000, 4'b0000};
    for (int i = 0; i < 12; i++) begin
      vin = 1'b1; op = t_op[i]; a = t_a[i]; b = t_b[i];
      @(negedge clk);
      total++;
      if ({vo1, res1} !== {1'b1, t_r[i]})
        $display("FAIL vec%0d_res got %b_%h want 1_%h",
                 i, vo1, res1, t_r[i]);
      else pass_cnt++;
      total++;
      if ({z1, c1, o1, n1} !== t_f[i])
        $display("FAIL vec%0d_flags zcon got %b want %b",
                 i, {z1, c1, o1, n1}, t_f[i]);
      else pass_cnt++;
    end
    vin = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int         sent = 0;
    int         recv = 0;
    logic       hold = 1'b0;
    logic [7:0] held = '0;
    logic [7:0] exp_r;
    do_reset();
    for (int c = 0; c < 40; c++) begin
      rdy_in = !(c >= 4 && c <= 6);
      vin    = (sent < 8);
      op     = 3'b010;
      a      = 8'(sent * 17);
      b      = 8'h01;
      #1;
      if (c == 3) begin
        total++;
        if (vo3 !== 1'b1)
          $display("FAIL b2b_latency got %b want 1", vo3);
        else pass_cnt++;
      end
      if (c == 5) begin
        total++;
        if ({rdy3, vo3} !== 2'b01)
          $display("FAIL b2b_full got rdy%b vo%b want rdy0 vo1",
                   rdy3, vo3);
        else pass_cnt++;
      end
      if (hold) begin
        total++;
        if ({vo3, res3} !== {1'b1, held})
          $display("FAIL b2b_hold c%0d got %b_%h want 1_%h",
                   c, vo3, res3, held);
        else pass_cnt++;
      end
      hold = vo3 & !rdy_in;
      held = res3;
      if (vo3 && rdy_in) begin
        exp_r = 8'(recv * 17 + 1);
        total++;
        if (recv >= 8)
          $display("FAIL b2b_extra got %h want none", res3);
        else if (res3 !== exp_r)
          $display("FAIL b2b_beat%0d got %h want %h",
                   recv, res3, exp_r);
        else pass_cnt++;
        recv++;
      end
      if (vin && rdy3) sent++;
      @(negedge clk);
    end
    vin = 1'b0;
    total++;
    if (recv !== 8)
      $display("FAIL b2b_count got %0d want 8", recv);
    else pass_cnt++;
  endtask

  task automatic test_enable();
    int         sent = 0;
    int         recv = 0;
    int         last = -1;
    logic       fr_vo = 1'b0;
    logic [7:0] fr_res = '0;
    logic [7:0] exp_r;
    do_reset();
    rdy_in = 1'b1;
    for (int c = 0; c < 30; c++) begin
      en  = !(c == 4 || c == 5);
      vin = (sent < 6);
      op  = 3'b110;
      a   = 8'(8'h30 + sent * 7);
      b   = 8'h05;
      #1;
      if (c == 4) begin
        fr_vo  = vo3;
        fr_res = res3;
      end
      if (c == 4 || c == 5) begin
        total++;
        if (rdy3 !== 1'b0)
          $display("FAIL en_ready c%0d got %b want 0", c, rdy3);
        else pass_cnt++;
      end
      if (c == 5 || c == 6) begin
        total++;
        if ({vo3, res3} !== {fr_vo, fr_res})
          $display("FAIL en_freeze c%0d got %b_%h want %b_%h",
                   c, vo3, res3, fr_vo, fr_res);
        else pass_cnt++;
      end
      if (vo3 && rdy_in && en) begin
        exp_r = 8'(8'h2B + recv * 7);
        total++;
        if (recv >= 6)
          $display("FAIL en_extra got %h want none", res3);
        else if (res3 !== exp_r)
          $display("FAIL en_beat%0d got %h want %h",
                   recv, res3, exp_r);
        else pass_cnt++;
        recv++;
        if (recv == 6) last = c;
      end
      if (vin && rdy3) sent++;
      @(negedge clk);
    end
    en  = 1'b1;
    vin = 1'b0;
    total++;
    if (recv !== 6)
      $display("FAIL en_count got %0d want 6", recv);
    else pass_cnt++;
    total++;
    if (last !== 10)
      $display("FAIL en_last_cycle got %0d want 10", last);
    else pass_cnt++;
  endtask

  task automatic test_reset_midflight();
    int seen = 0;
    int lat  = 0;
    do_reset();
    rdy_in = 1'b0;
    for (int c = 0; c < 3; c++) begin
      vin = 1'b1; op = 3'b010;
      a = 8'(8'h40 + c); b = 8'h01;
      @(negedge clk);
    end
    vin = 1'b0;
    total++;
    if (vo3 !== 1'b1)
      $display("FAIL mid_inflight got %b want 1", vo3);
    else pass_cnt++;
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({vo3, rdy3, res3, z3} !== {2'b00, 8'h00, 1'b1})
      $display("FAIL mid_rst got %b%b_%h_%b want 00_00_1",
               vo3, rdy3, res3, z3);
    else pass_cnt++;
    rst    = 1'b0;
    rdy_in = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (vo3) seen++;
    end
    total++;
    if (seen !== 0)
      $display("FAIL mid_ghost got %0d beats want 0", seen);
    else pass_cnt++;
    vin = 1'b1; op = 3'b111; a = 8'hFE; b = 8'h01;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      vin = 1'b0;
      if (vo3 && lat == 0) lat = k;
    end
    total++;
    if (lat !== 3)
      $display("FAIL slt_latency got %0d want 3", lat);
    else pass_cnt++;
    total++;
    if ({res3, z3, n3} !== {8'h01, 2'b00})
      $display("FAIL slt got %h_%b%b want 01_00", res3, z3, n3);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_flags();
    test_back_to_back();
    test_enable();
    test_reset_midflight();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
